// File: rtl/mux_pkg.sv
// mux_pkg: shared mode and output-stage types for the scanning channel selector
package mux_pkg;
  typedef enum logic {MUX_MANUAL = 1'b0, MUX_SCAN = 1'b1} mux_mode_t;
  typedef enum logic {OS_EMPTY = 1'b0, OS_FULL = 1'b1} os_state_t;
endpackage

// File: rtl/mux_scan_ptr.sv
// mux_scan_ptr: round-robin channel pointer, wraps NUM_CH-1 -> 0
module mux_scan_ptr #(
  parameter int NUM_CH = 8,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  output logic [SEL_W-1:0] ptr
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(NUM_CH - 1);
  logic [SEL_W-1:0] ptr_q, ptr_d;
  always_comb ptr_d = clr ? '0 : !en ? ptr_q : ptr_q == LAST ? '0 : ptr_q + 1'b1;
  always_ff @(posedge clk)
    if (!rst_n) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr = ptr_q;
endmodule

// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered N:1 channel selector, manual or round-robin scan, valid/ready output
module mux_scan_reg
  import mux_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 8,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ack,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);
  mux_mode_t         mode_e;
  os_state_t         os_q, os_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d, ptr, cand;
  logic              slot_free, capture;
  assign mode_e = mux_mode_t'(mode);
  mux_scan_ptr #(.NUM_CH(NUM_CH)) u_ptr (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (slot_free && mode_e == MUX_SCAN),
    .clr  (mode_e == MUX_MANUAL),
    .ptr  (ptr)
  );
  // out-of-range selects fall back to the last channel
  always_comb begin
    slot_free  = os_q == OS_EMPTY || out_ready;
    cand       = mode_e == MUX_SCAN ? ptr : sel > LAST_CH ? LAST_CH : sel;
    capture    = rst_n && slot_free && in_valid[cand];
    in_ack     = capture ? NUM_CH'(1) << cand : '0;
    os_d       = capture ? OS_FULL : slot_free ? OS_EMPTY : os_q;
    out_data_d = capture ? in_data[DATA_W*int'(cand) +: DATA_W] : out_data_q;
    out_ch_d   = capture ? cand : out_ch_q;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      os_q       <= OS_EMPTY;
      out_data_q <= '0;
      out_ch_q   <= '0;
    end else begin
      os_q       <= os_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
    end
  assign out_valid = os_q == OS_FULL;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
endmodule

// File: tb/tb_mux_scan_reg.sv
// tb_mux_scan_reg: scoreboard bench for mux_scan_reg, one lane with 8 channels and one with 5
module tb_mux_scan_reg;
  localparam int DW = 8;
  logic clk = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  function automatic void chk(int ln, string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL lane%0d %s: got %0h expected %0h at %0t", ln, nm, act, exp, $time);
    end
  endfunction
  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int N = g == 0 ? 8 : 5;
    localparam int SW = $clog2(N);
    logic          rst_n, mode, out_valid, out_ready;
    logic [SW-1:0] sel, out_ch;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]  in_valid, in_ack;
    logic [DW-1:0] out_data;
    int            q_ch[$];
    int            q_d[$];
    int            ptr_m = 0;
    bit            done = 0;
    mux_scan_reg #(.NUM_CH(N), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data),
      .in_valid(in_valid), .in_ack(in_ack), .out_data(out_data), .out_ch(out_ch),
      .out_valid(out_valid), .out_ready(out_ready)
    );
    function automatic logic [N*DW-1:0] rnd_data();
      logic [N*DW-1:0] d;
      for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom);
      return d;
    endfunction
    // reference: full iff the queue holds a word; candidate and pointer follow the selection rules
    task automatic step(input logic r, input logic m, input int s, input logic [N-1:0] v,
                        input logic rdy, input logic [N*DW-1:0] d);
      int c;
      bit free, cap;
      logic [N-1:0] ack_e;
      @(negedge clk);
      rst_n = r; mode = m; sel = SW'(s); in_valid = v; out_ready = rdy; in_data = d;
      #1;
      c = m ? ptr_m : (s > N - 1 ? N - 1 : s);
      free = q_ch.size() == 0 || rdy;
      cap = r && free && v[c];
      ack_e = cap ? N'(1) << c : '0;
      chk(g, "in_ack", 32'(in_ack), 32'(ack_e));
      @(posedge clk);
      if (!r) begin
        q_ch.delete(); q_d.delete(); ptr_m = 0;
      end else begin
        if (cap) begin q_ch.push_back(c); q_d.push_back(int'(d[c*DW +: DW])); end
        ptr_m = !m ? 0 : free ? (ptr_m + 1) % N : ptr_m;
      end
    endtask
    task automatic chk_reset();
      #1;
      chk(g, "rst_out_valid", 32'(out_valid), 0);
      chk(g, "rst_out_data", 32'(out_data), 0);
      chk(g, "rst_out_ch", 32'(out_ch), 0);
    endtask
    initial forever begin
      @(negedge clk);
      #3;
      if (rst_n === 1'b1) begin
        chk(g, "out_valid", 32'(out_valid), 32'(q_ch.size() != 0));
        if (out_valid && q_ch.size() != 0) begin
          chk(g, "out_data", 32'(out_data), 32'(q_d[0]));
          chk(g, "out_ch", 32'(out_ch), 32'(q_ch[0]));
          if (out_ready) begin void'(q_ch.pop_front()); void'(q_d.pop_front()); end
        end
      end
    end
    initial begin
      logic [N*DW-1:0] d;
      logic m;
      for (int i = 0; i < 3; i++) step(0, 0, 0, '1, 1, rnd_data());
      chk_reset();
      d = rnd_data(); d[3*DW +: DW] = 8'hA5;
      step(1, 0, 3, N'(1) << 3, 1, d);
      step(1, 0, 0, '0, 1, rnd_data());
      d = rnd_data(); d[1*DW +: DW] = 8'h11;
      step(1, 0, 1, N'(2), 1, d);
      for (int i = 0; i < 4; i++) step(1, 0, 1, '1, 0, rnd_data());
      step(1, 0, 1, '1, 1, rnd_data());
      step(1, 0, 0, '0, 1, rnd_data());
      for (int i = 0; i < 2 * N + 2; i++) step(1, 1, 0, N'(1) | (N'(1) << (N - 1)), 1, rnd_data());
      for (int s = 0; s < (1 << SW); s++) step(1, 0, s, '1, 1, rnd_data());
      step(1, 1, 0, '1, 1, rnd_data());
      step(1, 1, 0, '1, 0, rnd_data());
      step(0, 1, 0, '1, 0, rnd_data());
      chk_reset();
      m = 1'b0;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 9) == 0) m = ~m;
        step($urandom_range(0, 49) != 0, m, int'($urandom_range(0, (1 << SW) - 1)),
             N'($urandom), $urandom_range(0, 9) < 7, rnd_data());
      end
      for (int i = 0; i < 5 && q_ch.size() != 0; i++) step(1, 0, 0, '0, 1, rnd_data());
      chk(g, "drain_empty", 32'(q_ch.size()), 0);
      done = 1;
    end
  end
  initial begin
    wait (lane[0].done && lane[1].done);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end
endmodule
